// File: rtl/iic_pkg.sv
// Shared definitions for the IIC read-capture monitor.
// Holds the FSM state encoding, the control bytes the upstream master
// issues (write / read to the same device), and the capture buffer depth.
package iic_pkg;

   // Capture buffer depth (power of two)
   localparam int unsigned DEPTH = 128;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_ACK  = 2'd3;

   // Control bytes issued by the master: R/W bit is the LSB
   localparam logic [7:0] CTRL_WR = 8'hA0;
   localparam logic [7:0] CTRL_RD = 8'hA1;

endpackage

// File: rtl/iic_bus_sync.sv
// Synchronises the asynchronous SCL/SDA bus lines into the clk domain and
// detects SCL rising edges, START and STOP conditions.
// Ports:
//   clk_i, rst_ni   - clock, async active-low reset
//   scl_i, sda_i    - raw bus lines
//   scl_rise_o      - pulse: synced SCL went 0 -> 1
//   sda_o           - synced SDA aligned with the detection pulses
//   start_o         - pulse: SDA fell while SCL held high
//   stop_o          - pulse: SDA rose while SCL high
// All outputs are registered, so detection pulses trail the wire by
// SYNC_STAGES+1 clocks.
module iic_bus_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic sda_o,
   output logic start_o,
   output logic stop_o
);

   logic [SYNC_STAGES-1:0] scl_ff_q;
   logic [SYNC_STAGES-1:0] sda_ff_q;
   logic                   scl_h_q;
   logic                   sda_h_q;
   logic                   scl_s;
   logic                   sda_s;
   logic                   rise_c;
   logic                   start_c;
   logic                   stop_c;
   logic                   rise_q;
   logic                   sda_q;
   logic                   start_q;
   logic                   stop_q;

   assign scl_s = scl_ff_q[SYNC_STAGES-1];
   assign sda_s = sda_ff_q[SYNC_STAGES-1];

   // Edge / condition detection against the one-cycle history
   always_comb begin
      rise_c  = ~scl_h_q & scl_s;
      // START needs SCL stable high across both samples (no SCL edge)
      start_c = sda_h_q & ~sda_s & scl_h_q & scl_s;
      stop_c  = ~sda_h_q & sda_s & scl_s;
   end

   // Synchroniser chains reset to the idle-bus level (both lines high)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_ff_q <= '1;
         sda_ff_q <= '1;
         scl_h_q  <= 1'b1;
         sda_h_q  <= 1'b1;
         rise_q   <= 1'b0;
         sda_q    <= 1'b1;
         start_q  <= 1'b0;
         stop_q   <= 1'b0;
      end else begin
         scl_ff_q <= {scl_ff_q[SYNC_STAGES-2:0], scl_i};
         sda_ff_q <= {sda_ff_q[SYNC_STAGES-2:0], sda_i};
         scl_h_q  <= scl_s;
         sda_h_q  <= sda_s;
         rise_q   <= rise_c;
         sda_q    <= sda_s;
         start_q  <= start_c;
         stop_q   <= stop_c;
      end
   end

   assign scl_rise_o = rise_q;
   assign sda_o      = sda_q;
   assign start_o    = start_q;
   assign stop_o     = stop_q;

endmodule

// File: rtl/iic_rd_capture.sv
// Passive I2C monitor: assembles bytes + ACK from the bus, classifies them
// as address or data, and stores read-transaction data bytes in a capture
// buffer for downstream readback.
// Ports:
//   sys_clk, sys_rst_n - clock, async active-low reset
//   scl, sda           - raw I2C lines (asynchronous)
//   byte_valid         - pulse per completed byte + ACK
//   byte_data/byte_nack/byte_is_addr - last completed byte, held until next
//   rd_mode            - R/W bit of the current transaction
//   frame_done         - pulse on STOP
//   cap_cnt, cap_ovf   - stored byte count, sticky overflow flag
//   buf_raddr/buf_rdata - buffer read port, 1-cycle latency, read-first
//   clr                - synchronous clear of count, overflow, write pointer
module iic_rd_capture #(
   parameter int unsigned DEPTH       = iic_pkg::DEPTH,
   parameter int unsigned AW          = $clog2(DEPTH),
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          scl,
   input  logic          sda,
   output logic          byte_valid,
   output logic [7:0]    byte_data,
   output logic          byte_nack,
   output logic          byte_is_addr,
   output logic          rd_mode,
   output logic          frame_done,
   output logic [AW:0]   cap_cnt,
   output logic          cap_ovf,
   input  logic [AW-1:0] buf_raddr,
   output logic [7:0]    buf_rdata,
   input  logic          clr
);

   import iic_pkg::*;

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic scl_rise;
   logic sda_smp;
   logic start_det;
   logic stop_det;

   logic [1:0] state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic       is_addr_q, is_addr_d;
   logic       rd_mode_q, rd_mode_d;
   logic       byte_valid_q, byte_valid_d;
   logic [7:0] byte_data_q, byte_data_d;
   logic       byte_nack_q, byte_nack_d;
   logic       byte_is_addr_q, byte_is_addr_d;
   logic       frame_done_q, frame_done_d;

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW:0]   cap_cnt_q, cap_cnt_d;
   logic          cap_ovf_q, cap_ovf_d;
   logic          cap_req_c;
   logic          mem_we_c;
   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    buf_rdata_q;

   iic_bus_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_bus_sync (
      .clk_i      (sys_clk),
      .rst_ni     (sys_rst_n),
      .scl_i      (scl),
      .sda_i      (sda),
      .scl_rise_o (scl_rise),
      .sda_o      (sda_smp),
      .start_o    (start_det),
      .stop_o     (stop_det)
   );

   // Byte framing FSM: STOP beats START beats SCL rise
   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      shreg_d        = shreg_q;
      is_addr_d      = is_addr_q;
      rd_mode_d      = rd_mode_q;
      byte_valid_d   = 1'b0;
      byte_data_d    = byte_data_q;
      byte_nack_d    = byte_nack_q;
      byte_is_addr_d = byte_is_addr_q;
      frame_done_d   = 1'b0;

      if (stop_det) begin
         frame_done_d = 1'b1;
         state_d      = ST_IDLE;
         bit_cnt_d    = 4'd0;
      end else if (start_det) begin
         // Also covers repeated START: any partial byte is dropped
         state_d   = ST_ADDR;
         bit_cnt_d = 4'd0;
      end else if (scl_rise) begin
         case (state_q)
            ST_ADDR, ST_DATA: begin
               shreg_d   = {shreg_q[6:0], sda_smp};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_d == 4'd8) begin
                  state_d   = ST_ACK;
                  is_addr_d = (state_q == ST_ADDR);
                  // Bit just shifted in is the R/W bit of the address byte
                  if (state_q == ST_ADDR) rd_mode_d = sda_smp;
               end
            end
            ST_ACK: begin
               byte_valid_d   = 1'b1;
               byte_data_d    = shreg_q;
               byte_nack_d    = sda_smp;
               byte_is_addr_d = is_addr_q;
               state_d        = ST_DATA;
               bit_cnt_d      = 4'd0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= 4'd0;
         shreg_q        <= 8'd0;
         is_addr_q      <= 1'b0;
         rd_mode_q      <= 1'b0;
         byte_valid_q   <= 1'b0;
         byte_data_q    <= 8'd0;
         byte_nack_q    <= 1'b0;
         byte_is_addr_q <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         shreg_q        <= shreg_d;
         is_addr_q      <= is_addr_d;
         rd_mode_q      <= rd_mode_d;
         byte_valid_q   <= byte_valid_d;
         byte_data_q    <= byte_data_d;
         byte_nack_q    <= byte_nack_d;
         byte_is_addr_q <= byte_is_addr_d;
         frame_done_q   <= frame_done_d;
      end
   end

   // Capture control: only read-data bytes are stored, no wrap, clr wins
   always_comb begin
      cap_req_c = byte_valid_q & ~byte_is_addr_q & rd_mode_q;
      mem_we_c  = cap_req_c & ~clr & (cap_cnt_q != CNT_FULL);
      wptr_d    = wptr_q;
      cap_cnt_d = cap_cnt_q;
      cap_ovf_d = cap_ovf_q;
      if (clr) begin
         wptr_d    = '0;
         cap_cnt_d = '0;
         cap_ovf_d = 1'b0;
      end else if (cap_req_c) begin
         if (cap_cnt_q == CNT_FULL) begin
            cap_ovf_d = 1'b1;
         end else begin
            wptr_d    = wptr_q + AW'(1);
            cap_cnt_d = cap_cnt_q + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wptr_q    <= '0;
         cap_cnt_q <= '0;
         cap_ovf_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         cap_cnt_q <= cap_cnt_d;
         cap_ovf_q <= cap_ovf_d;
      end
   end

   // Buffer storage: contents are not reset
   always_ff @(posedge sys_clk) begin
      if (mem_we_c) mem_q[wptr_q] <= byte_data_q;
   end

   // Registered read port; same-cycle write returns old data
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) buf_rdata_q <= 8'd0;
      else            buf_rdata_q <= mem_q[buf_raddr];
   end

   assign byte_valid   = byte_valid_q;
   assign byte_data    = byte_data_q;
   assign byte_nack    = byte_nack_q;
   assign byte_is_addr = byte_is_addr_q;
   assign rd_mode      = rd_mode_q;
   assign frame_done   = frame_done_q;
   assign cap_cnt      = cap_cnt_q;
   assign cap_ovf      = cap_ovf_q;
   assign buf_rdata    = buf_rdata_q;

endmodule

// File: tb/tb_iic_rd_capture.sv
// Bench for iic_rd_capture: an I2C bus driver plus a byte-level reference
// model (expected event list, capture count, overflow flag, buffer image).
module tb_iic_rd_capture;
   import iic_pkg::*;

   localparam int Q = 4;   // sys_clk cycles per bus phase

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       scl       = 1'b1;
   logic       sda       = 1'b1;
   logic       clr       = 1'b0;
   logic [6:0] buf_raddr = 7'd0;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_nack;
   logic       byte_is_addr;
   logic       rd_mode;
   logic       frame_done;
   logic [7:0] cap_cnt;
   logic       cap_ovf;
   logic [7:0] buf_rdata;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   logic [9:0] ev_q[$];     // observed {is_addr, nack, data}
   logic [9:0] exp_q[$];    // expected {is_addr, nack, data}
   int         fd_cnt = 0;
   logic [7:0] mem_m [128];
   int         cnt_m = 0;
   logic       ovf_m = 1'b0;

   iic_rd_capture dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .scl          (scl),
      .sda          (sda),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_nack    (byte_nack),
      .byte_is_addr (byte_is_addr),
      .rd_mode      (rd_mode),
      .frame_done   (frame_done),
      .cap_cnt      (cap_cnt),
      .cap_ovf      (cap_ovf),
      .buf_raddr    (buf_raddr),
      .buf_rdata    (buf_rdata),
      .clr          (clr)
   );

   always #10 sys_clk = ~sys_clk;

   // Record byte and frame events away from the active edge
   always @(negedge sys_clk) begin
      if (byte_valid) ev_q.push_back({byte_is_addr, byte_nack, byte_data});
      if (frame_done) fd_cnt++;
   end

   initial begin
      repeat (60000) @(posedge sys_clk);
      $display("FAIL watchdog: simulation still running after 60000 cycles");
      $fatal(1);
   end

   task automatic phase();
      repeat (Q) @(posedge sys_clk);
      #1;
   endtask

   task automatic bus_start();
      sda = 1'b1; phase();
      scl = 1'b1; phase();
      sda = 1'b0; phase();
      scl = 1'b0; phase();
   endtask

   task automatic bus_stop();
      sda = 1'b0; phase();
      scl = 1'b1; phase();
      sda = 1'b1; phase();
      phase();
   endtask

   task automatic bus_bit(input logic b);
      sda = b;    phase();
      scl = 1'b1; phase();
      scl = 1'b0; phase();
   endtask

   // Full byte on the wire plus the model's view of it
   task automatic send(input logic [7:0] b, input logic ack, input logic is_addr, input logic rd);
      for (int i = 7; i >= 0; i--) bus_bit(b[i]);
      bus_bit(ack);
      exp_q.push_back({is_addr, ack, b});
      if (!is_addr && rd) begin
         if (cnt_m < 128) begin
            mem_m[cnt_m] = b;
            cnt_m++;
         end else begin
            ovf_m = 1'b1;
         end
      end
   endtask

   task automatic drain();
      repeat (12) @(posedge sys_clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(posedge sys_clk); #1;
      clr = 1'b0;
      cnt_m = 0;
      ovf_m = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      vectors++; if ({byte_valid, byte_nack, byte_is_addr, rd_mode, frame_done, cap_ovf} !== 6'd0) begin
         miscompares++; $display("FAIL reset_flags: got %b required 000000", {byte_valid, byte_nack, byte_is_addr, rd_mode, frame_done, cap_ovf});
      end
      vectors++; if (byte_data !== 8'd0) begin miscompares++; $display("FAIL reset_byte_data: got %h required 00", byte_data); end
      vectors++; if (cap_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cap_cnt: got %0d required 0", cap_cnt); end
      vectors++; if (buf_rdata !== 8'd0) begin miscompares++; $display("FAIL reset_buf_rdata: got %h required 00", buf_rdata); end
      sys_rst_n = 1'b1;
      cnt_m = 0; ovf_m = 1'b0;
      phase();
   endtask

   task automatic test_write_frame();
      int fd0;
      ev_q.delete(); exp_q.delete(); fd0 = fd_cnt;
      bus_start();
      send(CTRL_WR, 1'b0, 1'b1, 1'b0);
      send(8'h00, 1'b0, 1'b0, 1'b0);
      send(8'h3C, 1'b0, 1'b0, 1'b0);
      bus_stop(); drain();
      vectors++; if (ev_q.size() != exp_q.size()) begin
         miscompares++; $display("FAIL wr_frame_events: got %0d required %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         vectors++; if (ev_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL wr_frame_byte%0d: got %h required %h", i, ev_q[i], exp_q[i]); end
      end
      vectors++; if (rd_mode !== 1'b0) begin miscompares++; $display("FAIL wr_frame_rd_mode: got %b required 0", rd_mode); end
      vectors++; if (cap_cnt !== 8'(cnt_m)) begin miscompares++; $display("FAIL wr_frame_cap_cnt: got %0d required %0d", cap_cnt, cnt_m); end
      vectors++; if (fd_cnt - fd0 != 1) begin miscompares++; $display("FAIL wr_frame_frame_done: got %0d required 1", fd_cnt - fd0); end
   endtask

   task automatic test_repeated_start();
      ev_q.delete(); exp_q.delete();
      do_clr();
      bus_start();
      send(CTRL_WR, 1'b0, 1'b1, 1'b0);
      send(8'h00, 1'b0, 1'b0, 1'b0);
      bus_start();
      send(CTRL_RD, 1'b0, 1'b1, 1'b1);
      send(8'h11, 1'b0, 1'b0, 1'b1);
      send(8'h22, 1'b0, 1'b0, 1'b1);
      send(8'h33, 1'b1, 1'b0, 1'b1);
      bus_stop(); drain();
      vectors++; if (ev_q.size() != exp_q.size()) begin
         miscompares++; $display("FAIL rs_events: got %0d required %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         vectors++; if (ev_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rs_byte%0d: got %h required %h", i, ev_q[i], exp_q[i]); end
      end
      vectors++; if (cap_cnt !== 8'd3) begin miscompares++; $display("FAIL rs_cap_cnt: got %0d required 3", cap_cnt); end
      vectors++; if (byte_nack !== 1'b1) begin miscompares++; $display("FAIL rs_last_nack: got %b required 1", byte_nack); end
      vectors++; if (rd_mode !== 1'b1) begin miscompares++; $display("FAIL rs_rd_mode: got %b required 1", rd_mode); end
      for (int i = 0; i < cnt_m; i++) begin
         buf_raddr = 7'(i);
         @(posedge sys_clk); #1;
         vectors++; if (buf_rdata !== mem_m[i]) begin miscompares++; $display("FAIL rs_rdata[%0d]: got %h required %h", i, buf_rdata, mem_m[i]); end
      end
   endtask

   task automatic test_random_frames();
      logic rd;
      int   n;
      int   stops;
      int   fd0;
      ev_q.delete(); exp_q.delete(); fd0 = fd_cnt; stops = 0;
      for (int f = 0; f < 6; f++) begin
         rd = 1'($urandom_range(0, 1));
         n  = $urandom_range(1, 5);
         bus_start();
         send(rd ? CTRL_RD : CTRL_WR, 1'b0, 1'b1, rd);
         for (int j = 0; j < n; j++) send(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, rd);
         // Odd frames chain into the next one via a repeated START
         if (f % 2 == 0 || f == 5) begin
            bus_stop();
            stops++;
         end
         vectors++; if (rd_mode !== rd) begin miscompares++; $display("FAIL rnd_rd_mode%0d: got %b required %b", f, rd_mode, rd); end
      end
      drain();
      vectors++; if (ev_q.size() != exp_q.size()) begin
         miscompares++; $display("FAIL rnd_events: got %0d required %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         vectors++; if (ev_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rnd_byte%0d: got %h required %h", i, ev_q[i], exp_q[i]); end
      end
      vectors++; if (fd_cnt - fd0 != stops) begin miscompares++; $display("FAIL rnd_frame_done: got %0d required %0d", fd_cnt - fd0, stops); end
      vectors++; if (cap_cnt !== 8'(cnt_m)) begin miscompares++; $display("FAIL rnd_cap_cnt: got %0d required %0d", cap_cnt, cnt_m); end
      vectors++; if (cap_ovf !== ovf_m) begin miscompares++; $display("FAIL rnd_cap_ovf: got %b required %b", cap_ovf, ovf_m); end
      for (int i = 0; i < cnt_m; i++) begin
         buf_raddr = 7'(i);
         @(posedge sys_clk); #1;
         vectors++; if (buf_rdata !== mem_m[i]) begin miscompares++; $display("FAIL rnd_rdata[%0d]: got %h required %h", i, buf_rdata, mem_m[i]); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] want;
      ev_q.delete(); exp_q.delete();
      do_clr();
      bus_start();
      send(CTRL_RD, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 130; i++) send(8'(i), (i == 129), 1'b0, 1'b1);
      bus_stop(); drain();
      vectors++; if (ev_q.size() != exp_q.size()) begin
         miscompares++; $display("FAIL ovf_events: got %0d required %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         vectors++; if (ev_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL ovf_byte%0d: got %h required %h", i, ev_q[i], exp_q[i]); end
      end
      vectors++; if (cap_cnt !== 8'(cnt_m)) begin miscompares++; $display("FAIL ovf_cap_cnt: got %0d required %0d", cap_cnt, cnt_m); end
      vectors++; if (cap_ovf !== ovf_m) begin miscompares++; $display("FAIL ovf_flag: got %b required %b", cap_ovf, ovf_m); end
      for (int k = 0; k < 3; k++) begin
         int a;
         a = (k == 0) ? 127 : k - 1;   // last entry, then first two (no wrap)
         buf_raddr = 7'(a);
         @(posedge sys_clk); #1;
         vectors++; if (buf_rdata !== mem_m[a]) begin miscompares++; $display("FAIL ovf_rdata[%0d]: got %h required %h", a, buf_rdata, mem_m[a]); end
      end
      do_clr(); #1;
      vectors++; if (cap_cnt !== 8'd0 || cap_ovf !== 1'b0) begin
         miscompares++; $display("FAIL clr_after_ovf: got cnt %0d ovf %b required cnt 0 ovf 0", cap_cnt, cap_ovf);
      end
      buf_raddr = 7'd5;
      want = 8'd5;
      @(posedge sys_clk); #1;
      vectors++; if (buf_rdata !== want) begin miscompares++; $display("FAIL clr_keeps_mem: got %h required %h", buf_rdata, want); end
   endtask

   task automatic test_stop_midbyte();
      int fd0;
      ev_q.delete(); exp_q.delete(); fd0 = fd_cnt;
      bus_start();
      send(CTRL_RD, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) bus_bit(1'($urandom_range(0, 1)));
      bus_stop();
      // Clock a byte with no START: an idle monitor must ignore it
      scl = 1'b0; phase();
      for (int i = 0; i < 9; i++) bus_bit(1'($urandom_range(0, 1)));
      sda = 1'b1; phase();
      scl = 1'b1; phase();
      drain();
      vectors++; if (ev_q.size() != exp_q.size()) begin
         miscompares++; $display("FAIL stop_mid_events: got %0d required %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         vectors++; if (ev_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL stop_mid_byte%0d: got %h required %h", i, ev_q[i], exp_q[i]); end
      end
      vectors++; if (fd_cnt - fd0 != 1) begin miscompares++; $display("FAIL stop_mid_frame_done: got %0d required 1", fd_cnt - fd0); end
      vectors++; if (cap_cnt !== 8'(cnt_m)) begin miscompares++; $display("FAIL stop_mid_cap_cnt: got %0d required %0d", cap_cnt, cnt_m); end
   endtask

   task automatic test_reset_midbyte();
      bus_start();
      send(CTRL_RD, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)));
      sys_rst_n = 1'b0; phase();
      cnt_m = 0; ovf_m = 1'b0;
      vectors++; if (cap_cnt !== 8'd0 || byte_valid !== 1'b0) begin
         miscompares++; $display("FAIL rst_mid_state: got cnt %0d valid %b required 0 0", cap_cnt, byte_valid);
      end
      sys_rst_n = 1'b1; phase();
      ev_q.delete(); exp_q.delete();
      bus_start();
      send(CTRL_RD, 1'b0, 1'b1, 1'b1);
      send(8'h55, 1'b0, 1'b0, 1'b1);
      send(8'hAA, 1'b1, 1'b0, 1'b1);
      bus_stop(); drain();
      vectors++; if (ev_q.size() != exp_q.size()) begin
         miscompares++; $display("FAIL rst_mid_events: got %0d required %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         vectors++; if (ev_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rst_mid_byte%0d: got %h required %h", i, ev_q[i], exp_q[i]); end
      end
      vectors++; if (cap_cnt !== 8'd2) begin miscompares++; $display("FAIL rst_mid_cap_cnt: got %0d required 2", cap_cnt); end
      for (int i = 0; i < 2; i++) begin
         buf_raddr = 7'(i);
         @(posedge sys_clk); #1;
         vectors++; if (buf_rdata !== mem_m[i]) begin miscompares++; $display("FAIL rst_mid_rdata[%0d]: got %h required %h", i, buf_rdata, mem_m[i]); end
      end
      do_clr(); #1;
      vectors++; if (cap_cnt !== 8'd0 || cap_ovf !== 1'b0) begin
         miscompares++; $display("FAIL rst_mid_clr: got cnt %0d ovf %b required cnt 0 ovf 0", cap_cnt, cap_ovf);
      end
   endtask

   task automatic test_clr_collision();
      logic [7:0] d;
      logic [7:0] old0;
      bit         found;
      ev_q.delete(); exp_q.delete();
      old0 = mem_m[0];
      d = 8'hC3;
      bus_start();
      send(CTRL_RD, 1'b0, 1'b1, 1'b1);
      for (int i = 7; i >= 0; i--) bus_bit(d[i]);
      // ACK bit: hold SCL high and raise clr in the byte_valid cycle
      sda = 1'b0; phase();
      scl = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 16 && !found; k++) begin
         @(posedge sys_clk); #1;
         if (byte_valid) begin
            clr = 1'b1;
            found = 1'b1;
            @(posedge sys_clk); #1;
            clr = 1'b0;
         end
      end
      exp_q.push_back({1'b0, 1'b0, d});
      cnt_m = 0; ovf_m = 1'b0;
      vectors++; if (!found) begin miscompares++; $display("FAIL clr_col_timeout: got no byte_valid required pulse within 16 cycles"); end
      phase();
      scl = 1'b0; phase();
      vectors++; if (cap_cnt !== 8'd0) begin miscompares++; $display("FAIL clr_col_cap_cnt: got %0d required 0", cap_cnt); end
      buf_raddr = 7'd0;
      @(posedge sys_clk); #1;
      vectors++; if (buf_rdata !== old0) begin miscompares++; $display("FAIL clr_col_dropped: got %h required %h", buf_rdata, old0); end
      send(8'h3E, 1'b1, 1'b0, 1'b1);
      bus_stop(); drain();
      vectors++; if (ev_q.size() != exp_q.size()) begin
         miscompares++; $display("FAIL clr_col_events: got %0d required %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         vectors++; if (ev_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL clr_col_byte%0d: got %h required %h", i, ev_q[i], exp_q[i]); end
      end
      vectors++; if (cap_cnt !== 8'(cnt_m)) begin miscompares++; $display("FAIL clr_col_cap_cnt2: got %0d required %0d", cap_cnt, cnt_m); end
      buf_raddr = 7'd0;
      @(posedge sys_clk); #1;
      vectors++; if (buf_rdata !== mem_m[0]) begin miscompares++; $display("FAIL clr_col_rdata0: got %h required %h", buf_rdata, mem_m[0]); end
   endtask

   initial begin
      test_reset();
      test_write_frame();
      test_repeated_start();
      test_random_frames();
      test_overflow();
      test_stop_midbyte();
      test_reset_midbyte();
      test_clr_collision();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
